// File: rtl/hwpe_dma_loader_pkg.sv
// Shared constants and state encoding for the HWPE DMA loader.
package hwpe_dma_loader_pkg;

  localparam int HWPE_ADDR_WIDTH = 16;
  localparam int HWPE_SRC_AW     = 32;
  localparam int HWPE_LEN_W      = 16;
  localparam int HWPE_MAX_OUTST  = 2;

  localparam logic [15:0] HWPE_FMEM_ADDR1_START = 16'h0000;
  localparam logic [15:0] HWPE_FMEM_ADDR2_START = 16'h0800;
  localparam logic [15:0] HWPE_KMEM_ADDR_START  = 16'h1000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FMAP1 = 3'd1,
    ST_FMAP2 = 3'd2,
    ST_KERN  = 3'd3,
    ST_DRAIN = 3'd4
  } dma_state_e;

endpackage

// File: rtl/hwpe_dma_loader_if.sv
// Source-memory read port and HWPE memory write port of the loader.
interface hwpe_dma_loader_if import hwpe_dma_loader_pkg::*; #(
  parameter int ADDR_W = HWPE_ADDR_WIDTH,
  parameter int SRC_AW = HWPE_SRC_AW
);
  logic              src_req;
  logic [SRC_AW-1:0] src_addr;
  logic              src_gnt;
  logic              src_rvalid;
  logic [63:0]       src_rdata;
  logic              dma_wen;
  logic [ADDR_W-1:0] dma_wa;
  logic [63:0]       dma_wd;

  modport master (
    output src_req, src_addr,
    input  src_gnt, src_rvalid, src_rdata,
    output dma_wen, dma_wa, dma_wd
  );

  modport slave (
    input  src_req, src_addr,
    output src_gnt, src_rvalid, src_rdata,
    input  dma_wen, dma_wa, dma_wd
  );
endinterface

// File: rtl/hwpe_dma_loader_wr_addr.sv
// Receive-index counter and bank/kernel write-address mapping.
// Each accepted read beat becomes one registered HWPE memory write.
module hwpe_dma_loader_wr_addr import hwpe_dma_loader_pkg::*; #(
  parameter int                ADDR_W           = HWPE_ADDR_WIDTH,
  parameter int                LEN_W            = HWPE_LEN_W,
  parameter logic [ADDR_W-1:0] FMEM_ADDR1_START = HWPE_FMEM_ADDR1_START,
  parameter logic [ADDR_W-1:0] FMEM_ADDR2_START = HWPE_FMEM_ADDR2_START,
  parameter logic [ADDR_W-1:0] KMEM_ADDR_START  = HWPE_KMEM_ADDR_START
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              rvalid,
  input  logic [63:0]       rdata,
  input  logic [LEN_W-1:0]  fmap_beats,
  input  logic [LEN_W-1:0]  kern_beats,
  output logic              wen,
  output logic [ADDR_W-1:0] wa,
  output logic [63:0]       wd,
  output logic              fmap_last,
  output logic              kern_last
);

  // Two extra bits so 2F+K never overflows the index.
  localparam int CW = LEN_W + 2;

  logic [CW-1:0]     w, f_ext, f_x2, t_tot, off;
  logic [CW+2:0]     off_b;
  logic [ADDR_W-1:0] base, wa_nxt;

  assign f_ext  = CW'(fmap_beats);
  assign f_x2   = f_ext << 1;
  assign t_tot  = f_x2 + CW'(kern_beats);
  assign off_b  = {off, 3'b000};
  assign wa_nxt = base + off_b[ADDR_W-1:0];

  // Select the destination region and the offset within it for index w.
  always_comb begin
    base = FMEM_ADDR1_START;
    off  = w;
    if (w < f_ext) begin
      base = FMEM_ADDR1_START;
      off  = w;
    end else if (w < f_x2) begin
      base = FMEM_ADDR2_START;
      off  = w - f_ext;
    end else begin
      base = KMEM_ADDR_START;
      off  = w - f_x2;
    end
  end

  // Register the write one cycle after each beat and tag the last fmap/kernel beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w         <= '0;
      wen       <= 1'b0;
      wa        <= '0;
      wd        <= '0;
      fmap_last <= 1'b0;
      kern_last <= 1'b0;
    end else begin
      wen <= rvalid;
      if (clr) begin
        w <= '0;
      end else if (rvalid) begin
        w         <= w + CW'(1);
        wa        <= wa_nxt;
        wd        <= rdata;
        fmap_last <= (fmap_beats != '0) && (w == f_x2 - CW'(1));
        kern_last <= (kern_beats != '0) && (w == t_tot - CW'(1));
      end
    end
  end

endmodule

// File: rtl/hwpe_dma_loader.sv
// HWPE memory loader: fetches fmap bank 1, fmap bank 2 and kernel data from
// a source memory and writes them into the HWPE memories.
//
// state    | meaning
// ST_IDLE  | waiting for start, config sampled on start
// ST_FMAP1 | requesting bank-1 beats from cfg_fmap_src
// ST_FMAP2 | requesting bank-2 beats from cfg_fmap2_src
// ST_KERN  | requesting kernel beats from cfg_kern_src
// ST_DRAIN | all requests issued, waiting for the last write
module hwpe_dma_loader import hwpe_dma_loader_pkg::*; #(
  parameter int                ADDR_W           = HWPE_ADDR_WIDTH,
  parameter int                SRC_AW           = HWPE_SRC_AW,
  parameter int                LEN_W            = HWPE_LEN_W,
  parameter logic [ADDR_W-1:0] FMEM_ADDR1_START = HWPE_FMEM_ADDR1_START,
  parameter logic [ADDR_W-1:0] FMEM_ADDR2_START = HWPE_FMEM_ADDR2_START,
  parameter logic [ADDR_W-1:0] KMEM_ADDR_START  = HWPE_KMEM_ADDR_START,
  parameter int                MAX_OUTST        = HWPE_MAX_OUTST
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [SRC_AW-1:0]        cfg_fmap_src,
  input  logic [SRC_AW-1:0]        cfg_fmap2_src,
  input  logic [LEN_W-1:0]         cfg_fmap_beats,
  input  logic [SRC_AW-1:0]        cfg_kern_src,
  input  logic [LEN_W-1:0]         cfg_kern_beats,
  hwpe_dma_loader_if.master        bus,
  output logic                     busy,
  output logic                     done,
  output logic                     fmap_done,
  output logic                     kernel_done
);

  localparam int OW = $clog2(MAX_OUTST + 1);

  dma_state_e        state, state_nxt;
  logic [SRC_AW-1:0] fmap_src_q, fmap2_src_q, kern_src_q, base, idx_off;
  logic [LEN_W-1:0]  f_q, k_q, idx, phase_beats;
  logic [OW-1:0]     outst;
  logic              start_ok, rv_ok, room, last_beat, grant;
  logic              src_req_c, done_c;
  logic              wen, fmap_last, kern_last;

  assign start_ok    = start && (state == ST_IDLE);
  // Responses with nothing outstanding (e.g. stale after reset) are dropped.
  assign rv_ok       = bus.src_rvalid && (state != ST_IDLE) && (outst != '0);
  assign room        = (outst < OW'(MAX_OUTST)) ||
                       ((outst == OW'(MAX_OUTST)) && bus.src_rvalid);
  assign phase_beats = (state == ST_KERN) ? k_q : f_q;
  assign last_beat   = (idx == phase_beats - LEN_W'(1));
  assign grant       = src_req_c && bus.src_gnt;
  assign idx_off     = SRC_AW'({idx, 3'b000});

  assign bus.src_req  = src_req_c;
  assign bus.src_addr = (src_req_c || (state inside {ST_FMAP1, ST_FMAP2, ST_KERN}))
                        ? base + idx_off : '0;
  assign busy         = (state != ST_IDLE);
  assign done         = done_c;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state, request and completion; empty phases are skipped in one step.
  always_comb begin
    state_nxt = state;
    src_req_c = 1'b0;
    done_c    = 1'b0;
    base      = '0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (cfg_fmap_beats != '0)      state_nxt = ST_FMAP1;
          else if (cfg_kern_beats != '0) state_nxt = ST_KERN;
          else                           state_nxt = ST_DRAIN;
        end
      end
      ST_FMAP1: begin
        base      = fmap_src_q;
        src_req_c = room;
        if (room && bus.src_gnt && last_beat) state_nxt = ST_FMAP2;
      end
      ST_FMAP2: begin
        base      = fmap2_src_q;
        src_req_c = room;
        if (room && bus.src_gnt && last_beat)
          state_nxt = (k_q != '0) ? ST_KERN : ST_DRAIN;
      end
      ST_KERN: begin
        base      = kern_src_q;
        src_req_c = room;
        if (room && bus.src_gnt && last_beat) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((outst == '0) && !wen) begin
          done_c    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Config capture, per-phase request index and outstanding-read count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fmap_src_q  <= '0;
      fmap2_src_q <= '0;
      kern_src_q  <= '0;
      f_q         <= '0;
      k_q         <= '0;
      idx         <= '0;
      outst       <= '0;
    end else begin
      if (start_ok) begin
        fmap_src_q  <= cfg_fmap_src;
        fmap2_src_q <= cfg_fmap2_src;
        kern_src_q  <= cfg_kern_src;
        f_q         <= cfg_fmap_beats;
        k_q         <= cfg_kern_beats;
        idx         <= '0;
      end else if (grant) begin
        idx <= last_beat ? '0 : idx + LEN_W'(1);
      end
      if (grant && !rv_ok)      outst <= outst + OW'(1);
      else if (!grant && rv_ok) outst <= outst - OW'(1);
    end
  end

  // Status levels for the MCU: cleared on start, set after the tagged write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fmap_done   <= 1'b0;
      kernel_done <= 1'b0;
    end else if (start_ok) begin
      fmap_done   <= 1'b0;
      kernel_done <= 1'b0;
    end else begin
      if (wen && fmap_last) fmap_done   <= 1'b1;
      if (wen && kern_last) kernel_done <= 1'b1;
    end
  end

  hwpe_dma_loader_wr_addr #(
    .ADDR_W           (ADDR_W),
    .LEN_W            (LEN_W),
    .FMEM_ADDR1_START (FMEM_ADDR1_START),
    .FMEM_ADDR2_START (FMEM_ADDR2_START),
    .KMEM_ADDR_START  (KMEM_ADDR_START)
  ) u_wr_addr (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (start_ok),
    .rvalid     (rv_ok),
    .rdata      (bus.src_rdata),
    .fmap_beats (f_q),
    .kern_beats (k_q),
    .wen        (wen),
    .wa         (bus.dma_wa),
    .wd         (bus.dma_wd),
    .fmap_last  (fmap_last),
    .kern_last  (kern_last)
  );

  assign bus.dma_wen = wen;

endmodule

// File: tb/tb_hwpe_dma_loader.sv
// Directed bench for hwpe_dma_loader with a behavioural source memory.
module tb_hwpe_dma_loader;
  import hwpe_dma_loader_pkg::*;

  typedef struct {
    int          due;
    logic [63:0] data;
  } rsp_t;

  logic        clk, rst_n, start;
  logic [31:0] cfg_fmap_src, cfg_fmap2_src, cfg_kern_src;
  logic [15:0] cfg_fmap_beats, cfg_kern_beats;
  logic        busy, done, fmap_done, kernel_done;

  hwpe_dma_loader_if bus_if ();

  hwpe_dma_loader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .cfg_fmap_src   (cfg_fmap_src),
    .cfg_fmap2_src  (cfg_fmap2_src),
    .cfg_fmap_beats (cfg_fmap_beats),
    .cfg_kern_src   (cfg_kern_src),
    .cfg_kern_beats (cfg_kern_beats),
    .bus            (bus_if),
    .busy           (busy),
    .done           (done),
    .fmap_done      (fmap_done),
    .kernel_done    (kernel_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  bit          gnt_rand = 1'b0;
  int          lat_max  = 1;
  rsp_t        rq[$];
  int          rv_cyc_q[$];
  logic [15:0] wr_wa_q[$];
  logic [63:0] wr_wd_q[$];
  logic [15:0] exp_wa[$];
  logic [63:0] exp_wd[$];
  int          done_cnt, done_cyc, start_cyc, req_cnt;
  int          tb_outst, max_outst, addr_viol, lat_err;

  function automatic logic [63:0] src_word(input logic [31:0] a);
    return {a ^ 32'hC0DE_0000, ~a};
  endfunction

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic add_exp(input logic [15:0] wa, input logic [31:0] sa);
    exp_wa.push_back(wa);
    exp_wd.push_back(src_word(sa));
  endtask

  task automatic set_exp_main();
    exp_wa.delete();
    exp_wd.delete();
    add_exp(16'h0000, 32'h00); add_exp(16'h0008, 32'h08);
    add_exp(16'h0010, 32'h10); add_exp(16'h0018, 32'h18);
    add_exp(16'h0800, 32'h10); add_exp(16'h0808, 32'h18);
    add_exp(16'h0810, 32'h20); add_exp(16'h0818, 32'h28);
    add_exp(16'h1000, 32'h400); add_exp(16'h1008, 32'h408);
    add_exp(16'h1010, 32'h410);
  endtask

  task automatic check_writes();
    check_val("wr_count", 64'(wr_wa_q.size()), 64'(exp_wa.size()));
    for (int i = 0; i < exp_wa.size() && i < wr_wa_q.size(); i++) begin
      check_val($sformatf("wa[%0d]", i), 64'(wr_wa_q[i]), 64'(exp_wa[i]));
      check_val($sformatf("wd[%0d]", i), wr_wd_q[i], exp_wd[i]);
    end
  endtask

  task automatic check_rst_outs(input string tag);
    check_val({tag, "_ctl"}, 64'({bus_if.src_req, busy, done, fmap_done, kernel_done, bus_if.dma_wen}), 64'd0);
    check_val({tag, "_addr"}, 64'({bus_if.dma_wa, bus_if.src_addr}), 64'd0);
    check_val({tag, "_wd"}, bus_if.dma_wd, 64'd0);
  endtask

  task automatic clear_capture();
    wr_wa_q.delete();
    wr_wd_q.delete();
    done_cnt  = 0;
    req_cnt   = 0;
    max_outst = 0;
    addr_viol = 0;
    lat_err   = 0;
  endtask

  task automatic run_load(input logic [15:0] f, input logic [15:0] k,
                          input logic [31:0] fs, input logic [31:0] f2s, input logic [31:0] ks,
                          input bit disturb, input bit exp_fd, input bit exp_kd);
    cfg_fmap_beats = f;
    cfg_kern_beats = k;
    cfg_fmap_src   = fs;
    cfg_fmap2_src  = f2s;
    cfg_kern_src   = ks;
    clear_capture();
    @(negedge clk); #2;
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clk); #2;
    start = 1'b0;
    check_val("busy_after_start", 64'(busy), 64'd1);
    for (int n = 0; n < 400; n++) begin
      if (done_cnt != 0) break;
      @(negedge clk); #2;
      if (disturb && n == 1) begin
        start          = 1'b1;
        cfg_fmap_beats = 16'd9;
        cfg_kern_beats = 16'd5;
        cfg_fmap_src   = 32'h3000;
        cfg_fmap2_src  = 32'h5000;
        cfg_kern_src   = 32'h7000;
      end
      if (disturb && n == 2) start = 1'b0;
    end
    repeat (4) @(negedge clk);
    #2;
    check_val("done_pulses", 64'(done_cnt), 64'd1);
    check_val("busy_end", 64'(busy), 64'd0);
    check_val("fmap_done", 64'(fmap_done), 64'(exp_fd));
    check_val("kernel_done", 64'(kernel_done), 64'(exp_kd));
    check_val("wr_latency_err", 64'(lat_err), 64'd0);
    check_writes();
  endtask

  // Source memory responder and output monitor, evaluated mid-cycle.
  initial begin
    rsp_t r;
    int   t;
    bit   stall_prev;
    logic [31:0] prev_addr;
    stall_prev        = 1'b0;
    prev_addr         = '0;
    tb_outst          = 0;
    bus_if.src_gnt    = 1'b0;
    bus_if.src_rvalid = 1'b0;
    bus_if.src_rdata  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus_if.dma_wen) begin
        wr_wa_q.push_back(bus_if.dma_wa);
        wr_wd_q.push_back(bus_if.dma_wd);
        if (rv_cyc_q.size() == 0) lat_err++;
        else begin
          t = rv_cyc_q.pop_front();
          if (cyc - t != 1) lat_err++;
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (!rst_n) begin
        rq.delete();
        rv_cyc_q.delete();
        bus_if.src_rvalid = 1'b0;
        bus_if.src_gnt    = 1'b0;
        stall_prev        = 1'b0;
        tb_outst          = 0;
      end else begin
        if (rq.size() > 0 && rq[0].due <= cyc) begin
          r = rq.pop_front();
          bus_if.src_rvalid = 1'b1;
          bus_if.src_rdata  = r.data;
          tb_outst--;
          rv_cyc_q.push_back(cyc);
        end else begin
          bus_if.src_rvalid = 1'b0;
          bus_if.src_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
        end
        bus_if.src_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (stall_prev && (!bus_if.src_req || bus_if.src_addr !== prev_addr)) addr_viol++;
        if (bus_if.src_req) begin
          req_cnt++;
          if (bus_if.src_gnt) begin
            r.due  = cyc + int'($urandom_range(1, lat_max));
            r.data = src_word(bus_if.src_addr);
            rq.push_back(r);
            tb_outst++;
            if (tb_outst > max_outst) max_outst = tb_outst;
          end
        end
        stall_prev = bus_if.src_req && !bus_if.src_gnt;
        prev_addr  = bus_if.src_addr;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    start          = 1'b0;
    cfg_fmap_src   = '0;
    cfg_fmap2_src  = '0;
    cfg_kern_src   = '0;
    cfg_fmap_beats = '0;
    cfg_kern_beats = '0;
    repeat (3) @(negedge clk);
    #2;
    check_rst_outs("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full load, no stalls, fixed latency.
    gnt_rand = 1'b0;
    lat_max  = 1;
    set_exp_main();
    run_load(16'd4, 16'd3, 32'h0, 32'h10, 32'h400, 1'b0, 1'b1, 1'b1);

    // Same load with random grant stalls and response latency 1..4.
    gnt_rand = 1'b1;
    lat_max  = 4;
    run_load(16'd4, 16'd3, 32'h0, 32'h10, 32'h400, 1'b0, 1'b1, 1'b1);
    check_val("outst_le_max", 64'(max_outst <= 2), 64'd1);
    check_val("addr_stable", 64'(addr_viol), 64'd0);

    // Kernel only.
    gnt_rand = 1'b0;
    lat_max  = 1;
    exp_wa.delete();
    exp_wd.delete();
    add_exp(16'h1000, 32'h400);
    add_exp(16'h1008, 32'h408);
    run_load(16'd0, 16'd2, 32'h0, 32'h10, 32'h400, 1'b0, 1'b0, 1'b1);

    // Empty load.
    exp_wa.delete();
    exp_wd.delete();
    run_load(16'd0, 16'd0, 32'h0, 32'h10, 32'h400, 1'b0, 1'b0, 1'b0);
    check_val("t0_done_latency", 64'(done_cyc - start_cyc), 64'd1);
    check_val("t0_no_req", 64'(req_cnt), 64'd0);

    // Second start and config changes while busy have no effect.
    set_exp_main();
    run_load(16'd4, 16'd3, 32'h0, 32'h10, 32'h400, 1'b1, 1'b1, 1'b1);

    // Reset in the middle of a load, then a short load.
    cfg_fmap_beats = 16'd4;
    cfg_kern_beats = 16'd3;
    cfg_fmap_src   = 32'h0;
    cfg_fmap2_src  = 32'h10;
    cfg_kern_src   = 32'h400;
    clear_capture();
    @(negedge clk); #2;
    start = 1'b1;
    @(negedge clk); #2;
    start = 1'b0;
    for (int n = 0; n < 200 && wr_wa_q.size() < 5; n++) begin
      @(negedge clk); #2;
    end
    check_val("pre_rst_writes", 64'(wr_wa_q.size()), 64'd5);
    rst_n = 1'b0;
    #1;
    check_rst_outs("midrst");
    repeat (3) @(negedge clk);
    #2;
    check_rst_outs("midrst_hold");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    exp_wa.delete();
    exp_wd.delete();
    add_exp(16'h0000, 32'h0);
    add_exp(16'h0800, 32'h10);
    add_exp(16'h1000, 32'h400);
    run_load(16'd1, 16'd1, 32'h0, 32'h10, 32'h400, 1'b0, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hwpe_dma_loader.md
Name: hwpe_dma_loader

Overview:
- Sequencer that fills the HWPE on-chip memories through the `dma_wen/dma_wa/dma_wd` write port before an EAI instruction stream starts.
- It fetches 64-bit beats from a source memory over a req/gnt/rvalid port. It writes feature-map bank 1, then bank 2, then the kernel memory.
- Bank 2 is read from a separate source offset so the bank-1/bank-2 column overlap is reproduced.
- It raises `fmap_done`/`kernel_done` status for the MCU side. It replaces the bench-driven DMA loops.

Parameters:
- ADDR_W, 16, HWPE memory address width (`HWPE_ADDR_WIDTH`).
- SRC_AW, 32, source byte address width.
- LEN_W, 16, beat-count width.
- FMEM_ADDR1_START, 16'h0000, bank-1 base.
- FMEM_ADDR2_START, 16'h0800, bank-2 base.
- KMEM_ADDR_START, 16'h1000, kernel memory base.
- MAX_OUTST, 2, maximum outstanding source reads.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a load; ignored while busy
- cfg_fmap_src  in  SRC_AW  source byte address of bank-1 data
- cfg_fmap2_src  in  SRC_AW  source byte address of bank-2 data (overlap start)
- cfg_fmap_beats  in  LEN_W  64-bit beats per fmap bank
- cfg_kern_src  in  SRC_AW  source byte address of kernel data
- cfg_kern_beats  in  LEN_W  64-bit kernel beats
- src_req  out  1  source read request
- src_addr  out  SRC_AW  source byte address, 8-byte aligned
- src_gnt  in  1  request accepted when src_req&src_gnt
- src_rvalid  in  1  read data valid; in order; at least 1 cycle after gnt
- src_rdata  in  64  read data, byte 0 in [7:0]
- dma_wen  out  1  HWPE memory write enable
- dma_wa  out  ADDR_W  HWPE byte address
- dma_wd  out  64  write data
- busy  out  1  load in progress
- done  out  1  one-cycle completion pulse
- fmap_done  out  1  both fmap banks written (level)
- kernel_done  out  1  kernel memory written (level)

Behaviour:
- Reset: every output is 0; FSM = IDLE; all counters = 0.
- Config is sampled on start in IDLE. `F` = fmap_beats, `K` = kern_beats, `T` = 2F+K.
- start in IDLE: `fmap_done` and `kernel_done` clear; `busy` goes to 1 the next cycle.
- Request FSM: IDLE -> FMAP1 -> FMAP2 -> KERN -> DRAIN -> IDLE.
  - Any phase with 0 beats is skipped in the same transition.
  - T=0: go straight to DRAIN; `done` pulses 1 cycle after start.
- `src_addr` per phase:
  - FMAP1: cfg_fmap_src + 8i
  - FMAP2: cfg_fmap2_src + 8i
  - KERN: cfg_kern_src + 8i
  - i is the per-phase request index; it advances only on src_req&src_gnt.
- src_req is asserted only while outstanding < MAX_OUTST, or outstanding == MAX_OUTST with src_rvalid in that cycle.
- Outstanding counter: +1 on grant, −1 on rvalid; both in the same cycle leaves it unchanged.
- src_req/src_addr are held stable until granted. The FSM leaves a phase in the cycle its last beat is granted.
- Write side: global receive index w (0..T-1) increments on each src_rvalid.
  - Registered output, latency 1: the cycle after src_rvalid, dma_wen=1 and dma_wd=src_rdata.
  - dma_wa = FMEM_ADDR1_START+8w if w<F; FMEM_ADDR2_START+8(w−F) if w<2F; else KMEM_ADDR_START+8(w−2F).
  - Address arithmetic wraps modulo 2^ADDR_W with no error flag.
- dma_wen deasserts with no rvalid; dma_wa/dma_wd hold their last values.
- `fmap_done` sets in the cycle after the write of w=2F−1. It is 0 for the whole load when F=0.
- `kernel_done` sets after the write of w=T−1 when K>0.
- DRAIN: after the last write completes, `done`=1 for one cycle, `busy`=0, back to IDLE.
- src_rvalid in IDLE is ignored. A start pulse that coincides with `done` is ignored.
- rst_n low mid-load: immediate return to reset values. In-flight source responses after reset are ignored. Memory contents already written are not undone.

Decomposition:
- Shared package/header `hwpe_define.vh`: ADDR_W, memory base constants, FSM state encodings (IDLE=0, FMAP1=1, FMAP2=2, KERN=3, DRAIN=4).
- One natural sub-module: `hwpe_dma_wr_addr`. It holds the receive-index counter and the bank/kernel address mapping. The request FSM stays in the top.

Test Plan:
- Gnt always 1, rvalid 1 cycle after gnt, F=4, K=3, fmap_src=0x0, fmap2_src=0x10, kern_src=0x400:
  - 11 writes, dma_wa = 0x0,0x8,0x10,0x18, 0x800..0x818, 0x1000,0x1008,0x1010.
  - Bank-2 data equals source bytes 0x10–0x2F.
  - `done` pulses once; fmap_done=kernel_done=1.
- Random gnt stalls (50%) and rvalid latency 1–4: write order and data identical to the first scenario; outstanding never exceeds 2; src_addr stable while req&!gnt.
- F=0, K=2: only writes to 0x1000,0x1008; fmap_done=0; kernel_done=1.
- F=0, K=0: done pulses one cycle after start; no src_req; no dma_wen.
- start pulsed again while busy, F=4, K=3: ignored, still 11 writes. rst_n low after write 5, then a new load F=1,K=1: outputs 0 during reset, then 3 writes to 0x0,0x800,0x1000.
- cfg inputs changed mid-load: no effect on the current load's addresses.
